// File: rtl/saturn_bus_ctrl.sv
// Saturn nibble-bus initiator: serialises one core request into command,
// address and data slots, and hands read nibbles back as they arrive.
module saturn_bus_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [1:0]  i_req_op,
  input  logic [19:0] i_req_addr,
  input  logic [3:0]  i_req_count,
  input  logic [63:0] i_req_wdata,
  output logic        o_rd_valid,
  output logic [3:0]  o_rd_nibble,
  output logic        o_done,
  output logic        o_busy,
  output logic        o_bus_clk_en,
  output logic        o_bus_is_data,
  output logic [3:0]  o_bus_nibble_out,
  input  logic [3:0]  i_bus_nibble_in
);

  localparam logic [3:0] BUSCMD_PC_READ  = 4'h0;
  localparam logic [3:0] BUSCMD_DP_WRITE = 4'h3;
  localparam logic [3:0] BUSCMD_LOAD_PC  = 4'h4;
  localparam logic [3:0] BUSCMD_LOAD_DP  = 4'h5;

  localparam logic [1:0] OP_PC_LD_RD = 2'd0;
  localparam logic [1:0] OP_PC_RD    = 2'd2;
  localparam logic [1:0] OP_DP_WR    = 2'd3;

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_WCMD, S_DATA, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic        live_q, live_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  num_q, num_d;
  logic [1:0]  op_q, op_d;
  logic [19:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        bus_is_data_q, bus_is_data_d;
  logic [3:0]  bus_nib_q, bus_nib_d;
  logic        rd_valid_q, rd_valid_d;
  logic        strobe;
  logic        slot_is_data;
  logic [3:0]  slot_nib;

  assign div_d  = (div_q == DW'(CLK_DIV - 1)) ? '0 : div_q + DW'(1);
  assign strobe = (div_q == DW'(CLK_DIV - 1));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q       <= S_IDLE;
      div_q         <= '0;
      live_q        <= 1'b0;
      idx_q         <= '0;
      num_q         <= '0;
      op_q          <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      bus_is_data_q <= 1'b0;
      bus_nib_q     <= '0;
      rd_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      live_q        <= live_d;
      idx_q         <= idx_d;
      num_q         <= num_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      bus_is_data_q <= bus_is_data_d;
      bus_nib_q     <= bus_nib_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  // live_q: the bus registers already hold the current state's slot. The
  // first strobe after accept only loads the command, aligning to the slot grid.
  always_comb begin
    state_d = state_q;
    live_d  = live_q;
    idx_d   = idx_q;
    num_d   = num_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: if (i_req_valid) begin
        state_d = S_CMD;
        live_d  = 1'b0;
        idx_d   = '0;
        op_d    = i_req_op;
        addr_d  = i_req_addr;
        wdata_d = i_req_wdata;
        num_d   = {(i_req_count == 4'd0), i_req_count};
      end
      S_CMD: if (strobe) begin
        if (!live_q) live_d = 1'b1;
        else begin
          idx_d   = '0;
          state_d = (op_q == OP_PC_RD) ? S_DATA : S_ADDR;
        end
      end
      S_ADDR: if (strobe) begin
        if (idx_q == 5'd4) begin
          idx_d   = '0;
          state_d = (op_q == OP_DP_WR) ? S_WCMD : S_DATA;
        end else idx_d = idx_q + 5'd1;
      end
      S_WCMD: if (strobe) begin
        idx_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: if (strobe) begin
        if (idx_q == num_q - 5'd1) begin
          state_d = S_DONE;
          live_d  = 1'b0;
        end else idx_d = idx_q + 5'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    slot_is_data = 1'b0;
    slot_nib     = 4'h0;
    if (live_d) begin
      case (state_d)
        S_CMD: slot_nib = (op_q == OP_PC_LD_RD) ? BUSCMD_LOAD_PC :
                          (op_q == OP_PC_RD)    ? BUSCMD_PC_READ : BUSCMD_LOAD_DP;
        S_ADDR: begin
          slot_is_data = 1'b1;
          slot_nib     = addr_q[{idx_d[2:0], 2'b00} +: 4];
        end
        S_WCMD: slot_nib = BUSCMD_DP_WRITE;
        S_DATA: begin
          slot_is_data = 1'b1;
          slot_nib     = (op_q == OP_DP_WR) ? wdata_q[{idx_d[3:0], 2'b00} +: 4] : 4'h0;
        end
        default: ;
      endcase
    end
    bus_is_data_d = strobe ? slot_is_data : bus_is_data_q;
    bus_nib_d     = strobe ? slot_nib     : bus_nib_q;
    rd_valid_d    = strobe && (state_q == S_DATA) && (op_q != OP_DP_WR);
    o_req_ready   = (state_q == S_IDLE);
    o_busy        = (state_q != S_IDLE);
    o_done        = (state_q == S_DONE);
  end

  assign o_bus_clk_en     = strobe;
  assign o_bus_is_data    = bus_is_data_q;
  assign o_bus_nibble_out = bus_nib_q;
  assign o_rd_valid       = rd_valid_q;
  assign o_rd_nibble      = rd_valid_q ? i_bus_nibble_in : 4'h0;

endmodule

// File: tb/tb_saturn_bus_ctrl.sv
// Directed bench for saturn_bus_ctrl: a nibble ROM responder on a CLK_DIV=4
// instance plus a tiny echo responder on a CLK_DIV=2 instance.
module tb_saturn_bus_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0, n_fail = 0;

  logic        req_valid = 1'b0, req_ready, rd_valid, done, busy, bus_en, bus_isd;
  logic [1:0]  req_op = '0;
  logic [19:0] req_addr = '0;
  logic [3:0]  req_count = '0, rd_nib, bus_nib, bus_in;
  logic [63:0] req_wdata = '0;

  saturn_bus_ctrl #(.CLK_DIV(4)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_op(req_op), .i_req_addr(req_addr), .i_req_count(req_count), .i_req_wdata(req_wdata),
    .o_rd_valid(rd_valid), .o_rd_nibble(rd_nib), .o_done(done), .o_busy(busy),
    .o_bus_clk_en(bus_en), .o_bus_is_data(bus_isd), .o_bus_nibble_out(bus_nib),
    .i_bus_nibble_in(bus_in));

  logic        vb = 1'b0, rdy_b, rdv_b, done_b, busy_b, en_b, isd_b;
  logic [1:0]  opb = '0;
  logic [19:0] addrb = '0;
  logic [3:0]  cntb = '0, rdn_b, nib_b, in_b;
  logic [63:0] wdb = '0;

  saturn_bus_ctrl #(.CLK_DIV(2)) dut2 (
    .i_clk(clk), .i_reset(rst_n), .i_req_valid(vb), .o_req_ready(rdy_b),
    .i_req_op(opb), .i_req_addr(addrb), .i_req_count(cntb), .i_req_wdata(wdb),
    .o_rd_valid(rdv_b), .o_rd_nibble(rdn_b), .o_done(done_b), .o_busy(busy_b),
    .o_bus_clk_en(en_b), .o_bus_is_data(isd_b), .o_bus_nibble_out(nib_b),
    .i_bus_nibble_in(in_b));

  // ROM responder: commands select pointer/mode, five nibbles load a pointer
  // then auto-switch to read, pointers auto-increment.
  logic [3:0]  rom [256];
  logic        rom_ok = 1'b0;
  logic [1:0]  mode;
  logic        sel;
  logic [19:0] pc, dp, ptr;
  logic [2:0]  ln;
  assign ptr = sel ? dp : pc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= 2'd0; ln <= '0; bus_in <= '0; sel <= 1'b0;
      if (!rom_ok) begin
        for (int i = 0; i < 256; i++) rom[i] <= i[3:0];
        rom[8'h45] <= 4'hA; rom[8'h46] <= 4'hB; rom[8'h47] <= 4'hC;
        rom_ok <= 1'b1;
      end
    end else if (bus_en) begin
      if (!bus_isd) begin
        case (bus_nib)
          4'h4: begin mode <= 2'd1; sel <= 1'b0; ln <= '0; end
          4'h5: begin mode <= 2'd1; sel <= 1'b1; ln <= '0; end
          4'h0: begin mode <= 2'd2; sel <= 1'b0; end
          4'h1: begin mode <= 2'd2; sel <= 1'b1; end
          4'h3: begin mode <= 2'd3; sel <= 1'b1; end
          default: mode <= 2'd0;
        endcase
      end else begin
        case (mode)
          2'd1: begin
            if (sel) dp[{ln, 2'b00} +: 4] <= bus_nib; else pc[{ln, 2'b00} +: 4] <= bus_nib;
            ln <= ln + 3'd1;
            if (ln == 3'd4) mode <= 2'd2;
          end
          2'd2: begin
            bus_in <= rom[ptr[7:0]];
            if (sel) dp <= dp + 20'd1; else pc <= pc + 20'd1;
          end
          2'd3: begin rom[ptr[7:0]] <= bus_nib; dp <= dp + 20'd1; end
          default: ;
        endcase
      end
    end
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) in_b <= '0;
    else if (en_b) in_b <= isd_b ? (nib_b ^ 4'hA) : 4'h3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [4:0] slots[$];
  logic [3:0] rds[$];
  int rdc[$];
  int done_c, last_strobe;
  bit rdy_early;

  task automatic run(input logic [1:0] op, input logic [19:0] a, input logic [3:0] n,
                     input logic [63:0] wd, input bit hold);
    bit first = 1'b1;
    slots.delete(); rds.delete(); rdc.delete();
    done_c = -1; last_strobe = -1; rdy_early = 1'b0;
    @(negedge clk);
    chk("ready_idle", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_addr = a; req_count = n; req_wdata = wd;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      if (req_ready) rdy_early = 1'b1;
      if (bus_en) begin
        if (first) first = 1'b0;
        else begin slots.push_back({bus_isd, bus_nib}); last_strobe = cyc; end
      end
      if (rd_valid) begin rds.push_back(rd_nib); rdc.push_back(cyc); end
      if (done) begin done_c = cyc; break; end
    end
    chk("done_seen", 32'(done_c >= 0), 1);
  endtask

  task automatic chk_slots(input string tag, input logic [4:0] exp[$]);
    chk({tag, "_nslots"}, slots.size(), exp.size());
    for (int i = 0; i < exp.size() && i < slots.size(); i++) chk(tag, slots[i], exp[i]);
  endtask

  initial begin
    logic [4:0] e[$];
    int sc, c0, c1;
    bit seen, nb;
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdv", rd_valid, 0);
    chk("rst_bus", {bus_en, bus_isd, bus_nib}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // op0 read of three nibbles at 0x12345
    run(2'd0, 20'h12345, 4'd3, '0, 1'b0);
    e = '{5'h04, 5'h15, 5'h14, 5'h13, 5'h12, 5'h11, 5'h10, 5'h10, 5'h10};
    chk_slots("op0_slots", e);
    chk("op0_nrd", rds.size(), 3);
    if (rds.size() == 3) begin
      chk("op0_rd0", rds[0], 4'hA); chk("op0_rd1", rds[1], 4'hB); chk("op0_rd2", rds[2], 4'hC);
      chk("op0_gap01", rdc[1] - rdc[0], 4); chk("op0_gap12", rdc[2] - rdc[1], 4);
      chk("op0_done_last_rd", done_c, rdc[2]);
    end

    // op2 continue-PC read, count 0 means 16 nibbles from 0x12348
    run(2'd2, 20'h0, 4'd0, '0, 1'b0);
    e = '{5'h00};
    for (int i = 0; i < 16; i++) e.push_back(5'h10);
    chk_slots("op2_slots", e);
    chk("op2_nrd", rds.size(), 16);
    for (int i = 0; i < 16 && i < rds.size(); i++) chk("op2_rd", rds[i], 32'((8 + i) & 15));

    // op3 write 6,9 at 0x00010
    run(2'd3, 20'h00010, 4'd2, 64'h96, 1'b0);
    e = '{5'h05, 5'h10, 5'h11, 5'h10, 5'h10, 5'h10, 5'h03, 5'h16, 5'h19};
    chk_slots("op3_slots", e);
    chk("op3_nrd", rds.size(), 0);
    chk("op3_done_after_slot", done_c, last_strobe + 1);

    // valid held high: no accept while busy, re-accept right after done
    run(2'd1, 20'h12345, 4'd1, '0, 1'b1);
    chk("hold_no_accept_busy", rdy_early, 0);
    chk("hold_rd", (rds.size() == 1) ? rds[0] : 4'hF, 4'hA);
    @(negedge clk);
    chk("hold_ready_after_done", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("hold_second_busy", busy, 1);
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("hold_second_done", seen, 1);

    // reset in the middle of the address phase
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd1; req_addr = 20'h00010; req_count = 4'd2;
    sc = 0;
    for (int k = 0; k < 100 && sc < 4; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (bus_en) sc++;
    end
    @(posedge clk); #2;
    chk("mid_busy", busy, 1);
    chk("mid_isdata", bus_isd, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_ready", req_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_bus", {bus_en, bus_isd, bus_nib}, 0);
    chk("arst_rd", {rd_valid, rd_nib}, 0);
    nb = 1'b0;
    repeat (3) begin @(negedge clk); if (done) nb = 1'b1; end
    chk("arst_no_done", nb | done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run(2'd1, 20'h00010, 4'd2, '0, 1'b0);
    chk("post_rst_nrd", rds.size(), 2);
    if (rds.size() == 2) begin
      chk("post_rst_rd0", rds[0], 4'h6); chk("post_rst_rd1", rds[1], 4'h9);
    end

    // CLK_DIV=2 instance: last address nibble 5, read slot echoes 0^A
    @(negedge clk);
    vb = 1'b1; opb = 2'd0; addrb = 20'h5432C; cntb = 4'd1;
    c0 = -1; c1 = -1; seen = 1'b0; nb = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      vb = 1'b0;
      if (en_b) begin c0 = c1; c1 = cyc; end
      if (rdv_b) begin
        chk("div2_rd", rdn_b, 4'hA);
        chk("div2_rd_nonstrobe", en_b, 0);
        chk("div2_done_with_rd", done_b, 1);
        nb = 1'b1;
      end
      if (done_b) seen = 1'b1;
    end
    chk("div2_done", seen, 1);
    chk("div2_rd_seen", nb, 1);
    chk("div2_strobe_gap", c1 - c0, 2);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end
endmodule
